// File: rtl/bram_fifo_stream_if.sv
// rtl/bram_fifo_stream_if.sv - valid/ready word stream bundle shared by producer and consumer sides
interface bram_fifo_stream_if #(
  parameter int DATA_WIDTH = 25
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bram_fifo_stream.sv
// rtl/bram_fifo_stream.sv - valid/ready adapter around a flagless 1-cycle-latency BRAM FIFO
// Tracks BRAM occupancy and prefetches into a 2-entry register buffer for full-rate registered output.
module bram_fifo_stream #(
  parameter int  DATA_WIDTH = 25,
  parameter int  DEPTH      = 256,
  localparam int CNT_W      = $clog2(DEPTH + 3)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  bram_fifo_stream_if.slave     s,
  bram_fifo_stream_if.master    m,
  output logic [DATA_WIDTH-1:0] fifo_di,
  output logic                  fifo_wren,
  output logic                  fifo_rden,
  input  logic [DATA_WIDTH-1:0] fifo_do,
  output logic                  fifo_clear,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]      mem_cnt;
  logic                  rd_pend;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  rst_done;
  logic                  pop;
  logic [2:0]            occ;

  // Input side stays closed until the first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_done <= 1'b0;
    else      rst_done <= 1'b1;
  end

  assign full       = (mem_cnt == DEPTH_C);
  assign s.ready    = rst_done & ~full & ~clear;
  assign fifo_wren  = s.valid & s.ready;
  assign fifo_di    = s.data;
  assign fifo_clear = clear;

  assign pop = (buf_cnt != 2'd0) & m.ready;
  assign occ = {1'b0, buf_cnt} + {2'b00, rd_pend};

  // Launch a read only if the buffer can still take the word when it lands next cycle.
  assign fifo_rden = ~clear & (mem_cnt != '0) & (occ <= ({2'b00, pop} + 3'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_cnt <= '0;
      rd_pend <= 1'b0;
    end else if (clear) begin
      mem_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= fifo_rden;
      unique case ({fifo_wren, fifo_rden})
        2'b10:   mem_cnt <= mem_cnt + CNT_W'(1);
        2'b01:   mem_cnt <= mem_cnt - CNT_W'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

  // rd_pend marks fifo_do as valid this cycle; it lands at the buffer tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_cnt <= 2'd0;
      head    <= '0;
      tail    <= '0;
    end else if (clear) begin
      buf_cnt <= 2'd0;
    end else begin
      unique case ({pop, rd_pend})
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            head <= fifo_do;
          end else begin
            head <= tail;
            tail <= fifo_do;
          end
        end
        2'b10: begin
          head    <= tail;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b01: begin
          if (buf_cnt == 2'd0) head <= fifo_do;
          else                 tail <= fifo_do;
          buf_cnt <= buf_cnt + 2'd1;
        end
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  assign m.data  = head;
  assign m.valid = (buf_cnt != 2'd0);

  assign count = mem_cnt + CNT_W'(rd_pend) + CNT_W'(buf_cnt);
  assign empty = (count == '0);

endmodule

// File: tb/tb_bram_fifo_stream.sv
// tb/tb_bram_fifo_stream.sv - directed and random checks of bram_fifo_stream against a BRAM model and scoreboard
module tb_bram_fifo_stream;
  localparam int DW    = 25;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 3);

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [DW-1:0] fifo_di;
  logic [DW-1:0] fifo_do;
  logic          fifo_wren;
  logic          fifo_rden;
  logic          fifo_clear;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  bram_fifo_stream_if #(.DATA_WIDTH(DW)) s_if ();
  bram_fifo_stream_if #(.DATA_WIDTH(DW)) m_if ();

  bram_fifo_stream #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .s          (s_if),
    .m          (m_if),
    .fifo_di    (fifo_di),
    .fifo_wren  (fifo_wren),
    .fifo_rden  (fifo_rden),
    .fifo_do    (fifo_do),
    .fifo_clear (fifo_clear),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flagless BRAM FIFO: registered read data, pointers wrap at DEPTH.
  logic [DW-1:0] bram [DEPTH];
  int wp, rp, bcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= 0; rp <= 0; bcnt <= 0;
    end else if (fifo_clear) begin
      wp <= 0; rp <= 0; bcnt <= 0;
    end else begin
      if (fifo_wren) begin
        bram[wp] <= fifo_di;
        wp <= (wp + 1) % DEPTH;
      end
      if (fifo_rden) begin
        fifo_do <= bram[rp];
        rp <= (rp + 1) % DEPTH;
      end
      bcnt <= bcnt + int'(fifo_wren) - int'(fifo_rden);
    end
  end

  logic [DW-1:0] sbq [$];
  always @(negedge clk) begin
    if (!rst) begin
      sbq.delete();
    end else begin
      chk("count", 32'(count), 32'(sbq.size()));
      chk("empty_flag", 32'(empty), 32'(sbq.size() == 0));
      chk("full_flag", 32'(full), 32'(bcnt == DEPTH));
      chk("rden_on_empty_bram", 32'(fifo_rden && bcnt == 0), 32'h0);
      chk("wren_on_full_bram", 32'(fifo_wren && bcnt == DEPTH), 32'h0);
      if (m_if.valid && m_if.ready) begin
        if (sbq.size() == 0) chk("pop_without_data", 32'(sbq.size()), 32'h1);
        else                 chk("pop_data", 32'(m_if.data), 32'(sbq.pop_front()));
      end
      if (clear) sbq.delete();
      if (s_if.valid && s_if.ready) sbq.push_back(s_if.data);
    end
  end

  initial begin
    int idx, sent, got, first_push, first_pop, last_pop, cyc;
    rst = 1'b0; clear = 1'b0;
    s_if.valid = 1'b0; s_if.data = '0; m_if.ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_if.valid), 32'h0);
    chk("rst_m_data", 32'(m_if.data), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_wren", 32'(fifo_wren), 32'h0);
    chk("rst_rden", 32'(fifo_rden), 32'h0);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rst_release_s_ready", 32'(s_if.ready), 32'h1);

    // single word latency
    step();
    s_if.valid = 1'b1; s_if.data = 25'h0123456; m_if.ready = 1'b1;
    @(negedge clk);
    chk("single_accept", 32'(s_if.ready), 32'h1);
    step();
    s_if.valid = 1'b0;
    @(negedge clk); chk("lat_n1_valid", 32'(m_if.valid), 32'h0);
    @(negedge clk); chk("lat_n2_valid", 32'(m_if.valid), 32'h0);
    @(negedge clk); chk("lat_n3_valid", 32'(m_if.valid), 32'h1);
    chk("lat_n3_data", 32'(m_if.data), 32'h0123456);
    @(negedge clk); chk("single_empty_after", 32'(empty), 32'h1);

    // fill to DEPTH+2 under back-pressure
    step();
    m_if.ready = 1'b0; idx = 0;
    repeat (14) begin
      s_if.valid = (idx < 10); s_if.data = DW'(idx);
      @(negedge clk);
      if (s_if.valid && s_if.ready) idx++;
      step();
    end
    chk("fill_accepted", 32'(idx), 32'd6);
    @(negedge clk);
    chk("fill_count", 32'(count), 32'd6);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_s_ready", 32'(s_if.ready), 32'h0);
    step();
    s_if.valid = 1'b0; m_if.ready = 1'b1;
    repeat (12) step();
    chk("fill_drained", 32'(sbq.size()), 32'h0);
    chk("fill_empty", 32'(empty), 32'h1);

    // full-rate stream
    sent = 0; got = 0; first_push = -1; first_pop = -1; last_pop = -1;
    for (int c = 0; c < 1100 && got < 1000; c++) begin
      s_if.valid = (sent < 1000); s_if.data = DW'(sent); m_if.ready = 1'b1;
      @(negedge clk);
      if (s_if.valid && s_if.ready) begin
        if (sent == 0) first_push = c;
        sent++;
      end
      if (m_if.valid && m_if.ready) begin
        if (got == 0) first_pop = c;
        last_pop = c;
        got++;
      end
      step();
    end
    s_if.valid = 1'b0;
    chk("stream_got", 32'(got), 32'd1000);
    chk("stream_latency", 32'(first_pop - first_push), 32'd3);
    chk("stream_no_bubble", 32'(last_pop - first_pop), 32'd999);

    // random valid/ready with pointer wrap
    sent = 0; got = 0;
    for (int c = 0; c < 20000 && got < 500; c++) begin
      s_if.valid = (sent < 500) && ($urandom_range(0, 3) != 0);
      s_if.data  = DW'($urandom);
      m_if.ready = ($urandom_range(0, 3) > 1);
      @(negedge clk);
      if (s_if.valid && s_if.ready) sent++;
      if (m_if.valid && m_if.ready) got++;
      step();
    end
    s_if.valid = 1'b0;
    chk("random_got", 32'(got), 32'd500);

    // clear with buffered words and a read in flight
    m_if.ready = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      s_if.valid = 1'b1; s_if.data = DW'(32'h100 + i);
      step();
    end
    s_if.valid = 1'b0; m_if.ready = 1'b1;
    step();
    clear = 1'b1; s_if.valid = 1'b1; s_if.data = 25'h1555555;
    @(negedge clk);
    chk("clear_s_ready", 32'(s_if.ready), 32'h0);
    chk("clear_fifo_clear", 32'(fifo_clear), 32'h1);
    chk("clear_wren", 32'(fifo_wren), 32'h0);
    chk("clear_rden", 32'(fifo_rden), 32'h0);
    step();
    clear = 1'b0; s_if.valid = 1'b0;
    @(negedge clk);
    chk("clear_count", 32'(count), 32'h0);
    chk("clear_m_valid", 32'(m_if.valid), 32'h0);
    step();
    s_if.valid = 1'b1; s_if.data = 25'h1FFFFFF;
    step();
    s_if.valid = 1'b0;
    cyc = 0;
    while (!m_if.valid && cyc < 10) begin
      step();
      cyc++;
    end
    chk("clear_next_valid", 32'(m_if.valid), 32'h1);
    chk("clear_next_data", 32'(m_if.data), 32'h1FFFFFF);
    repeat (3) step();

    // asynchronous reset in the middle of traffic
    m_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_if.valid = 1'b1; s_if.data = DW'(32'h200 + i);
      step();
    end
    #2 rst = 1'b0;
    #1;
    chk("midrst_m_valid", 32'(m_if.valid), 32'h0);
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_empty", 32'(empty), 32'h1);
    chk("midrst_full", 32'(full), 32'h0);
    chk("midrst_wren", 32'(fifo_wren), 32'h0);
    step();
    rst = 1'b1; s_if.valid = 1'b0;
    step();
    @(negedge clk);
    chk("midrst_release_s_ready", 32'(s_if.ready), 32'h1);
    step();
    s_if.valid = 1'b1; s_if.data = 25'h0ABCDEF; m_if.ready = 1'b1;
    step();
    s_if.valid = 1'b0;
    repeat (6) step();
    chk("final_drain", 32'(sbq.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
